// File: rtl/riscv_dmem_slave.sv
// Data-memory slave for a RISC-V core: word-addressed array with byte-enable
// writes, programmable read/write wait states and a sticky out-of-range flag.
// Writes take priority over reads when both are requested in IDLE. A request
// in service is never pre-empted, and it is aborted if its req drops.
module riscv_dmem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_WAIT     = 1,
  parameter int WR_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [3:0]  rd_be,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_gnt,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_gnt,
  output logic        o_addr_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_BUSY = 2'd1;
  localparam logic [1:0] WR_BUSY = 2'd2;

  // Counter preload: one cycle is spent sampling the request in IDLE.
  localparam logic [3:0]  RD_LOAD = 4'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [3:0]  WR_LOAD = 4'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rd_data_q;
  logic        addr_err_q;
  logic        rd_gnt_c, wr_gnt_c;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   rd_idx, wr_idx;
  logic          rd_in_range, wr_in_range;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   rd_word;

  // The byte lane of an address and the read byte enables have no effect:
  // the full word is always returned and the master picks the sub-word.
  logic unused_bits;
  assign unused_bits = ^{rd_be, rd_addr[1:0], wr_addr[1:0]};

  assign rd_idx      = rd_addr[31:2];
  assign wr_idx      = wr_addr[31:2];
  assign rd_in_range = ({2'b00, rd_idx} < DEPTH_W);
  assign wr_in_range = ({2'b00, wr_idx} < DEPTH_W);
  assign rd_ptr      = rd_idx[AW-1:0];
  assign wr_ptr      = wr_idx[AW-1:0];

  // Asynchronous array read; out-of-range reads return zero.
  assign rd_word = rd_in_range ? mem[rd_ptr] : 32'h0;

  // Next-state, counter and grant decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_gnt_c = 1'b0;
    wr_gnt_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          if (WR_WAIT == 0) begin
            wr_gnt_c = 1'b1;
          end else begin
            state_d = WR_BUSY;
            cnt_d   = WR_LOAD;
          end
        end else if (rd_req) begin
          if (RD_WAIT == 0) begin
            rd_gnt_c = 1'b1;
          end else begin
            state_d = RD_BUSY;
            cnt_d   = RD_LOAD;
          end
        end
      end
      RD_BUSY: begin
        if (!rd_req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          rd_gnt_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_BUSY: begin
        if (!wr_req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          wr_gnt_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Grants are forced low while reset is held so no zero-wait access slips
  // through and no pending write can touch the array.
  assign rd_gnt     = rd_gnt_c & rst_n;
  assign wr_gnt     = wr_gnt_c & rst_n;
  assign rd_data    = rd_gnt ? rd_word : rd_data_q;
  assign o_addr_err = addr_err_q;

  // FSM state, wait counter, held read word and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_data_q  <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_gnt) begin
        rd_data_q <= rd_word;
      end
      if ((rd_gnt && !rd_in_range) || (wr_gnt && !wr_in_range)) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  // Byte-masked array write on the edge ending the write grant cycle.
  always_ff @(posedge clk) begin
    if (wr_gnt && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_ptr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_slave.sv
// Self-checking bench for riscv_dmem_slave. Two instances share the clock:
// dut_a (RD_WAIT=1, WR_WAIT=0) and dut_b (RD_WAIT=3, WR_WAIT=2). Expected read
// words are queued when a read is issued and popped when rd_gnt appears.
module tb_riscv_dmem_slave;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_rd_req, a_wr_req, a_rd_gnt, a_wr_gnt, a_err;
  logic [3:0]  a_rd_be, a_wr_be;
  logic [31:0] a_rd_addr, a_wr_addr, a_wr_data, a_rd_data;
  logic        b_rst_n, b_rd_req, b_wr_req, b_rd_gnt, b_wr_gnt, b_err;
  logic [3:0]  b_rd_be, b_wr_be;
  logic [31:0] b_rd_addr, b_wr_addr, b_wr_data, b_rd_data;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  logic [31:0] exp_rd_q [$];
  logic [31:0] model [longint];
  logic        err_at_gnt;

  logic        o_rd_gnt, o_wr_gnt, o_err;
  logic [31:0] o_rd_data;
  assign o_rd_gnt  = (cur == 0) ? a_rd_gnt  : b_rd_gnt;
  assign o_wr_gnt  = (cur == 0) ? a_wr_gnt  : b_wr_gnt;
  assign o_err     = (cur == 0) ? a_err     : b_err;
  assign o_rd_data = (cur == 0) ? a_rd_data : b_rd_data;

  riscv_dmem_slave #(.DEPTH_WORDS(DEPTH), .RD_WAIT(1), .WR_WAIT(0)) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .rd_req(a_rd_req), .rd_be(a_rd_be), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_gnt(a_rd_gnt),
    .wr_req(a_wr_req), .wr_be(a_wr_be), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_gnt(a_wr_gnt), .o_addr_err(a_err)
  );

  riscv_dmem_slave #(.DEPTH_WORDS(DEPTH), .RD_WAIT(3), .WR_WAIT(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .rd_req(b_rd_req), .rd_be(b_rd_be), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_gnt(b_rd_gnt),
    .wr_req(b_wr_req), .wr_be(b_wr_be), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_gnt(b_wr_gnt), .o_addr_err(b_err)
  );

  function automatic longint mkey(input logic [31:0] addr);
    return (longint'(cur) << 32) | longint'(addr[31:2]);
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    return ({2'b00, addr[31:2]} < 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (!in_range(addr)) return 32'h0;
    if (model.exists(mkey(addr))) return model[mkey(addr)];
    return 32'hxxxxxxxx;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] be);
    logic [31:0] w;
    if (!in_range(addr)) return;
    w = model.exists(mkey(addr)) ? model[mkey(addr)] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    model[mkey(addr)] = w;
  endfunction

  task automatic drive_rd(input logic req, input logic [31:0] addr, input logic [3:0] be);
    if (cur == 0) begin a_rd_req = req; a_rd_addr = addr; a_rd_be = be; end
    else          begin b_rd_req = req; b_rd_addr = addr; b_rd_be = be; end
  endtask

  task automatic drive_wr(input logic req, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    if (cur == 0) begin a_wr_req = req; a_wr_addr = addr; a_wr_data = data; a_wr_be = be; end
    else          begin b_wr_req = req; b_wr_addr = addr; b_wr_data = data; b_wr_be = be; end
  endtask

  task automatic do_read(input logic [31:0] addr, input int lat);
    logic [31:0] exp;
    int k;
    bit got;
    exp_rd_q.push_back(model_read(addr));
    @(negedge clk);
    drive_rd(1'b1, addr, 4'($urandom_range(0, 15)));
    k = 0; got = 0; exp = 32'h0;
    while (!got && k <= lat + 8) begin
      #1;
      if (o_rd_gnt) begin
        got = 1;
        err_at_gnt = o_err;
        exp = exp_rd_q.pop_front();
        $display("rd  dut%0d addr=%h data=%h lat=%0d", cur, addr, o_rd_data, k);
        checks++;
        if (k != lat) begin
          errors++; $display("FAIL rd_latency dut%0d addr=%h got=%0d exp=%0d", cur, addr, k, lat);
        end
        checks++;
        if (o_rd_data !== exp) begin
          errors++; $display("FAIL rd_data dut%0d addr=%h got=%h exp=%h", cur, addr, o_rd_data, exp);
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      checks++; errors++;
      exp = exp_rd_q.pop_front();
      $display("FAIL rd_timeout dut%0d addr=%h got=no_gnt exp=gnt_after_%0d", cur, addr, lat);
    end
    @(negedge clk);
    drive_rd(1'b0, 32'h0, 4'h0);
    #1;
    checks++;
    if (o_rd_gnt !== 1'b0) begin
      errors++; $display("FAIL rd_gnt_release dut%0d got=%b exp=0", cur, o_rd_gnt);
    end
    if (got) begin
      checks++;
      if (o_rd_data !== exp) begin
        errors++; $display("FAIL rd_data_hold dut%0d got=%h exp=%h", cur, o_rd_data, exp);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int lat);
    int k;
    bit got;
    @(negedge clk);
    drive_wr(1'b1, addr, data, be);
    k = 0; got = 0;
    while (!got && k <= lat + 8) begin
      #1;
      if (o_wr_gnt) begin
        got = 1;
        model_write(addr, data, be);
        $display("wr  dut%0d addr=%h data=%h be=%h lat=%0d", cur, addr, data, be, k);
        checks++;
        if (k != lat) begin
          errors++; $display("FAIL wr_latency dut%0d addr=%h got=%0d exp=%0d", cur, addr, k, lat);
        end
        checks++;
        if (o_rd_gnt !== 1'b0) begin
          errors++; $display("FAIL wr_stray_rd_gnt dut%0d got=%b exp=0", cur, o_rd_gnt);
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wr_timeout dut%0d addr=%h got=no_gnt exp=gnt_after_%0d", cur, addr, lat);
    end
    @(negedge clk);
    drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++;
    if (o_wr_gnt !== 1'b0) begin
      errors++; $display("FAIL wr_gnt_release dut%0d got=%b exp=0", cur, o_wr_gnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({o_rd_gnt, o_wr_gnt, o_err} !== 3'b000) begin
      errors++; $display("FAIL %s_flags dut%0d got=%b exp=000", tag, cur, {o_rd_gnt, o_wr_gnt, o_err});
    end
    checks++;
    if (o_rd_data !== 32'h0) begin
      errors++; $display("FAIL %s_rd_data dut%0d got=%h exp=00000000", tag, cur, o_rd_data);
    end
  endtask

  task automatic test_reset();
    a_rst_n = 0; b_rst_n = 0;
    a_rd_req = 0; a_rd_be = 0; a_rd_addr = 0; a_wr_be = 4'hF; a_wr_addr = 0; a_wr_data = 0;
    b_rd_req = 0; b_rd_be = 0; b_rd_addr = 0; b_wr_be = 0; b_wr_addr = 0; b_wr_data = 0;
    b_wr_req = 0;
    a_wr_req = 1;  // zero-wait write must not be granted during reset
    repeat (3) @(negedge clk);
    #1;
    cur = 0; check_reset_outputs("reset");
    cur = 1; check_reset_outputs("reset");
    @(negedge clk);
    a_wr_req = 0;
    a_rst_n = 1; b_rst_n = 1;
    $display("reset released");
  endtask

  task automatic test_basic();
    cur = 0;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(32'h10, 1);
    checks++;
    if (o_rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_word got=%h exp=deadbeef", o_rd_data);
    end
    do_read(32'h13, 1);
  endtask

  task automatic test_byte_enables();
    cur = 0;
    do_write(32'h10, 32'h000000AA, 4'h1, 0);
    do_read(32'h10, 1);
    checks++;
    if (o_rd_data !== 32'hDEADBEAA) begin
      errors++; $display("FAIL be_low_byte got=%h exp=deadbeaa", o_rd_data);
    end
    do_write(32'h10, 32'hFFFFFFFF, 4'h0, 0);
    do_read(32'h10, 1);
    do_write(32'h10, 32'h55006600, 4'hA, 0);
    do_read(32'h10, 1);
    checks++;
    if (o_rd_data !== 32'h55AD66AA) begin
      errors++; $display("FAIL be_mixed got=%h exp=55ad66aa", o_rd_data);
    end
  endtask

  task automatic test_random_traffic();
    cur = 0;
    for (int i = 0; i < 8; i++) do_write(32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
    for (int i = 0; i < 8; i++)
      do_write(32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 8; i++) do_read(32'h100 + 32'(4 * i), 1);
  endtask

  task automatic test_out_of_range();
    cur = 0;
    do_write(32'h0, 32'h0BADF00D, 4'hF, 0);
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL oor_err_before got=%b exp=0", o_err);
    end
    do_read(32'h00001000, 1);
    checks++;
    if (err_at_gnt !== 1'b0) begin
      errors++; $display("FAIL oor_err_early got=%b exp=0", err_at_gnt);
    end
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL oor_err_set got=%b exp=1", o_err);
    end
    do_write(32'h00001000, 32'hFFFFFFFF, 4'hF, 0);
    do_read(32'h0, 1);
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL oor_err_sticky got=%b exp=1", o_err);
    end
  endtask

  task automatic test_simultaneous();
    int k, wr_k, rd_k;
    bit wr_on, rd_on, bad;
    logic [31:0] exp;
    cur = 1;
    wr_k = -1; rd_k = -1; bad = 0; k = 0;
    exp_rd_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    drive_wr(1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    drive_rd(1'b1, 32'h40, 4'hF);
    wr_on = 1; rd_on = 1;
    while (rd_on && k < 20) begin
      #1;
      if ((o_wr_gnt && !wr_on) || (o_rd_gnt && !rd_on)) bad = 1;
      if (o_wr_gnt && wr_k < 0) begin
        wr_k = k;
        model_write(32'h40, 32'hCAFEF00D, 4'hF);
        $display("wr  dut1 addr=00000040 data=cafef00d be=f lat=%0d (with rd pending)", k);
      end
      if (o_rd_gnt && rd_k < 0) begin
        rd_k = k;
        exp = exp_rd_q.pop_front();
        $display("rd  dut1 addr=00000040 data=%h lat=%0d (after wr)", o_rd_data, k);
        checks++;
        if (o_rd_data !== exp) begin
          errors++; $display("FAIL simul_rd_data got=%h exp=%h", o_rd_data, exp);
        end
      end
      @(negedge clk);
      k++;
      if (wr_on && wr_k >= 0) begin drive_wr(1'b0, 32'h0, 32'h0, 4'h0); wr_on = 0; end
      if (rd_on && rd_k >= 0) begin drive_rd(1'b0, 32'h0, 4'h0); rd_on = 0; end
    end
    if (rd_on || wr_on) begin
      drive_rd(1'b0, 32'h0, 4'h0);
      drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
      exp_rd_q.delete();
    end
    #1;
    checks++;
    if (wr_k != 2) begin
      errors++; $display("FAIL simul_wr_cycle got=%0d exp=2", wr_k);
    end
    checks++;
    if (rd_k != 6) begin
      errors++; $display("FAIL simul_rd_cycle got=%0d exp=6", rd_k);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL simul_gnt_without_req got=1 exp=0");
    end
  endtask

  task automatic test_abort();
    cur = 1;
    @(negedge clk);
    drive_rd(1'b1, 32'h40, 4'hF);
    #1;
    checks++;
    if (o_rd_gnt !== 1'b0) begin
      errors++; $display("FAIL abort_early_gnt got=%b exp=0", o_rd_gnt);
    end
    @(negedge clk);
    drive_rd(1'b0, 32'h0, 4'h0);
    #1;
    checks++;
    if (o_rd_gnt !== 1'b0 || o_rd_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_drop got=%b/%h exp=0/cafef00d", o_rd_gnt, o_rd_data);
    end
    $display("rd  dut1 addr=00000040 aborted");
    do_write(32'h44, 32'h12345678, 4'hF, 2);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (o_rd_gnt !== 1'b0 || o_rd_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_hold got=%b/%h exp=0/cafef00d", o_rd_gnt, o_rd_data);
    end
    do_read(32'h44, 3);
  endtask

  task automatic test_reset_mid_write();
    cur = 1;
    do_read(32'h00001000, 3);
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL rst_pre_err got=%b exp=1", o_err);
    end
    do_write(32'h20, 32'h11111111, 4'hF, 2);
    do_read(32'h20, 3);
    @(negedge clk);
    drive_wr(1'b1, 32'h20, 32'h22222222, 4'hF);
    #1;
    checks++;
    if (o_wr_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_wr_early0 got=%b exp=0", o_wr_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_wr_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_wr_early1 got=%b exp=0", o_wr_gnt);
    end
    b_rst_n = 0;
    $display("rst dut1 asserted mid-write");
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (o_wr_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_held_wr_gnt got=%b exp=0", o_wr_gnt);
    end
    @(negedge clk);
    drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
    b_rst_n = 1;
    #1;
    check_reset_outputs("rst_after");
    do_read(32'h20, 3);
    checks++;
    if (o_rd_data !== 32'h11111111) begin
      errors++; $display("FAIL rst_array_kept got=%h exp=11111111", o_rd_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_random_traffic();
    test_out_of_range();
    test_simultaneous();
    test_abort();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_slave.md
RISCV_DMEM_SLAVE -- requirements
Module: riscv_dmem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data array.
REQ-002 SHALL have parameter RD_WAIT, default 1: wait cycles before a read grant, legal range 0..15.
REQ-003 SHALL have parameter WR_WAIT, default 0: wait cycles before a write grant, legal range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports rd_req, input, 1 bit; rd_be, input, 4 bits; rd_addr, input, 32 bits: read request, byte enables and byte address.
REQ-007 SHALL have ports rd_data, output, 32 bits; rd_gnt, output, 1 bit: read word and read grant.
REQ-008 SHALL have ports wr_req, input, 1 bit; wr_be, input, 4 bits; wr_addr, input, 32 bits; wr_data, input, 32 bits: write request, byte enables, byte address and data.
REQ-009 SHALL have port wr_gnt, output, 1 bit: write grant.
REQ-010 SHALL have port o_addr_err, output, 1 bit: sticky flag for an out-of-range access.

Function
REQ-011 SHALL decode the word index as addr[31:2] and ignore addr[1:0].
REQ-012 SHALL treat an access as out of range when the word index is greater than or equal to DEPTH_WORDS.
REQ-013 SHALL implement FSM states IDLE, RD_BUSY and WR_BUSY, plus a 4-bit down-counter cnt.
REQ-014 In IDLE with wr_req=1 and WR_WAIT>0, SHALL go to WR_BUSY and load cnt=WR_WAIT-1 on the next edge.
REQ-015 In IDLE with wr_req=1 and WR_WAIT=0, SHALL assert wr_gnt combinationally in the same cycle and stay in IDLE.
REQ-016 In IDLE with rd_req=1, wr_req=0 and RD_WAIT>0, SHALL go to RD_BUSY and load cnt=RD_WAIT-1.
REQ-017 In IDLE with rd_req=1, wr_req=0 and RD_WAIT=0, SHALL assert rd_gnt combinationally in the same cycle.
REQ-018 In a BUSY state with cnt>0, SHALL decrement cnt each cycle.
REQ-019 In a BUSY state with cnt=0, SHALL assert the matching gnt for exactly one cycle and return to IDLE on the next edge.
REQ-020 Latency: gnt SHALL be asserted exactly WAIT cycles after the cycle in which the request is first sampled in IDLE.
REQ-021 A master stalls on req&~gnt, so gnt SHALL never be asserted while the matching req=0.
REQ-022 On a simultaneous rd_req and wr_req in IDLE, the write SHALL be served first; the read is then served from IDLE after the write grant.
REQ-023 A request already in service SHALL NOT be pre-empted by the other request type.
REQ-024 If the serviced req drops before its grant (abort), the FSM SHALL return to IDLE on the next edge with no grant and no array update.
REQ-025 A write SHALL update only the bytes whose wr_be bit is 1, on the clock edge ending the wr_gnt cycle.
REQ-026 A write with wr_be=4'h0 SHALL be granted normally and SHALL modify nothing.
REQ-027 During the rd_gnt cycle, rd_data SHALL present the full addressed word regardless of rd_be; the array read is asynchronous.
REQ-028 Outside the rd_gnt cycle, rd_data SHALL hold the last granted read word in a register, so it is stable for the master's latch.
REQ-029 Sub-word selection and sign extension SHALL be left to the master.
REQ-030 An out-of-range access SHALL still be granted with normal timing.
REQ-031 An out-of-range read SHALL return 32'h0, and an out-of-range write SHALL be dropped.
REQ-032 An out-of-range access SHALL set o_addr_err=1 on the grant edge; o_addr_err SHALL stay 1 until reset.
REQ-033 A write granted in cycle t followed by a read of the same address SHALL return the new data (read-after-write).

Reset
REQ-034 While rst_n=0: state SHALL be IDLE, cnt=0, rd_gnt=0, wr_gnt=0, rd_data register=32'h0, o_addr_err=0.
REQ-035 Reset asserted mid-access SHALL abort the access with no grant; a write not yet granted SHALL NOT modify the array.
REQ-036 Array contents SHALL NOT be reset.

Verification
REQ-037 RD_WAIT=1: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> wr_gnt in the request cycle; rd_gnt one cycle after the read request; rd_data=32'hDEADBEEF.
REQ-038 Byte enables: after the REQ-037 write, write 32'h000000AA to 0x10 with be=4'h1 -> a read of 0x10 returns 32'hDEADBEAA.
REQ-039 RD_WAIT=3 with rd_req and wr_req raised in the same cycle -> wr_gnt first, then rd_gnt 3 cycles after the read is first sampled in IDLE; a grant is never seen with its req low.
REQ-040 Abort: rd_req held 1 cycle with RD_WAIT=3, then dropped -> no rd_gnt, FSM in IDLE, rd_data unchanged.
REQ-041 Out of range with DEPTH_WORDS=1024: read 0x00001000 -> rd_gnt asserted, rd_data=32'h0, o_addr_err rises on the grant edge and stays 1 through later legal accesses.
REQ-042 Reset mid-write with WR_WAIT=2 to 0x20 holding 32'h11111111 -> no wr_gnt; after reset, a read of 0x20 returns 32'h11111111 and all outputs hold the REQ-034 values.
